// File: rtl/curtain_pkg.sv
// Shared types and constants for the curtain stepper controller.
package curtain_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'b001,
    ST_OPENING = 3'b010,
    ST_CLOSING = 3'b100
  } state_e;

  // Phase index to unipolar coil drive A,B,C,D.
  localparam logic [3:0] COIL_TAB [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  localparam int unsigned STEP_DIV_DEF  = 8000;
  localparam int unsigned POS_MAX_DEF   = 2048;
  localparam int unsigned TH_BRIGHT_DEF = 180;
  localparam int unsigned TH_DARK_DEF   = 80;
  localparam int unsigned POS_W_DEF     = 12;

endpackage

// File: rtl/step_tick_gen.sv
// Step-rate divider: one-cycle tick every STEP_DIV cycles while enabled.
module step_tick_gen #(
  parameter int unsigned STEP_DIV = 8000
) (
  input  logic clk8m,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int unsigned CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  assign tick = en && (r_cnt == CNT_LAST);

  always_ff @(posedge clk8m or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!en || tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/curtain_stepper_ctrl.sv
// Curtain stepper controller: light-driven auto mode with hysteresis,
// manual override, position tracking, travel-end and limit-switch stops.
module curtain_stepper_ctrl
  import curtain_pkg::*;
#(
  parameter int unsigned STEP_DIV  = STEP_DIV_DEF,
  parameter int unsigned POS_MAX   = POS_MAX_DEF,
  parameter int unsigned TH_BRIGHT = TH_BRIGHT_DEF,
  parameter int unsigned TH_DARK   = TH_DARK_DEF,
  parameter int unsigned POS_W     = POS_W_DEF
) (
  input  logic             clk8m,
  input  logic             rst,
  input  logic [7:0]       light_level,
  input  logic             light_vld,
  input  logic             auto_en,
  input  logic             btn_open,
  input  logic             btn_close,
  input  logic             lim_open,
  input  logic             lim_closed,
  output logic [3:0]       coil,
  output logic             busy,
  output logic             dir,
  output logic [POS_W-1:0] pos
);

  localparam logic [POS_W-1:0] P_MAX     = POS_W'(POS_MAX);
  localparam logic [POS_W-1:0] P_ONE     = POS_W'(1);
  localparam logic [7:0]       LV_BRIGHT = 8'(TH_BRIGHT);
  localparam logic [7:0]       LV_DARK   = 8'(TH_DARK);

  state_e           r_state;
  logic [1:0]       r_phase;
  logic [3:0]       r_coil;
  logic             r_busy;
  logic             r_dir;
  logic [POS_W-1:0] r_pos;

  logic w_moving;
  logic w_tick;
  logic w_btn;
  logic w_req_close;
  logic w_req_open;

  assign w_moving = (r_state != ST_IDLE);

  step_tick_gen #(
    .STEP_DIV (STEP_DIV)
  ) u_step_tick_gen (
    .clk8m (clk8m),
    .rst   (rst),
    .en    (w_moving),
    .tick  (w_tick)
  );

  // Any button press masks the light sample; both buttons together request nothing.
  assign w_btn       = btn_open | btn_close;
  assign w_req_close = w_btn ? (btn_close & ~btn_open)
                             : (auto_en & light_vld & (light_level >= LV_BRIGHT));
  assign w_req_open  = w_btn ? (btn_open & ~btn_close)
                             : (auto_en & light_vld & (light_level <= LV_DARK));

  always_ff @(posedge clk8m or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_phase <= 2'd0;
      r_coil  <= 4'b0000;
      r_busy  <= 1'b0;
      r_dir   <= 1'b0;
      r_pos   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_close && (r_pos != P_MAX) && !lim_closed) begin
            r_state <= ST_CLOSING;
            r_dir   <= 1'b1;
            r_busy  <= 1'b1;
            r_coil  <= COIL_TAB[r_phase];
          end else if (w_req_open && (r_pos != '0) && !lim_open) begin
            r_state <= ST_OPENING;
            r_dir   <= 1'b0;
            r_busy  <= 1'b1;
            r_coil  <= COIL_TAB[r_phase];
          end
        end

        ST_CLOSING: begin
          if (lim_closed) begin
            r_pos   <= P_MAX;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_coil  <= 4'b0000;
          end else begin
            if (w_tick) begin
              r_phase <= r_phase + 2'd1;
              r_pos   <= r_pos + P_ONE;
              r_coil  <= COIL_TAB[r_phase + 2'd1];
            end
            // Later assignments override the coil update above when stopping.
            if (w_btn || (w_tick && (r_pos == P_MAX - P_ONE))) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_coil  <= 4'b0000;
            end
          end
        end

        ST_OPENING: begin
          if (lim_open) begin
            r_pos   <= '0;
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_coil  <= 4'b0000;
          end else begin
            if (w_tick) begin
              r_phase <= r_phase - 2'd1;
              r_pos   <= r_pos - P_ONE;
              r_coil  <= COIL_TAB[r_phase - 2'd1];
            end
            if (w_btn || (w_tick && (r_pos == P_ONE))) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_coil  <= 4'b0000;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          r_coil  <= 4'b0000;
        end
      endcase
    end
  end

  assign coil = r_coil;
  assign busy = r_busy;
  assign dir  = r_dir;
  assign pos  = r_pos;

endmodule

// File: tb/tb_curtain_stepper_ctrl.sv
// Bench for curtain_stepper_ctrl: directed scenarios plus random stimulus
// against a behavioural model of the curtain motion.
`timescale 1ns/1ps
module tb_curtain_stepper_ctrl;

  localparam int unsigned STEP_DIV  = 4;
  localparam int unsigned POS_MAX   = 8;
  localparam int unsigned TH_BRIGHT = 180;
  localparam int unsigned TH_DARK   = 80;
  localparam int unsigned POS_W     = 12;

  logic             clk8m = 1'b0;
  logic             rst = 1'b1;
  logic [7:0]       light_level = 8'd0;
  logic             light_vld = 1'b0;
  logic             auto_en = 1'b0;
  logic             btn_open = 1'b0;
  logic             btn_close = 1'b0;
  logic             lim_open = 1'b0;
  logic             lim_closed = 1'b0;
  logic [3:0]       coil;
  logic             busy;
  logic             dir;
  logic [POS_W-1:0] pos;

  curtain_stepper_ctrl #(
    .STEP_DIV  (STEP_DIV),
    .POS_MAX   (POS_MAX),
    .TH_BRIGHT (TH_BRIGHT),
    .TH_DARK   (TH_DARK),
    .POS_W     (POS_W)
  ) dut (
    .clk8m       (clk8m),
    .rst         (rst),
    .light_level (light_level),
    .light_vld   (light_vld),
    .auto_en     (auto_en),
    .btn_open    (btn_open),
    .btn_close   (btn_close),
    .lim_open    (lim_open),
    .lim_closed  (lim_closed),
    .coil        (coil),
    .busy        (busy),
    .dir         (dir),
    .pos         (pos)
  );

  always #5 clk8m = ~clk8m;

  int n_vec = 0;
  int n_bad = 0;

  // Model: motion is -1 (opening), 0 (stopped), +1 (closing).
  int m_mv    = 0;
  int m_pos   = 0;
  int m_phase = 0;
  int m_el    = 0;
  bit m_dir   = 1'b0;
  bit cur_ae  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic timeout(input string tag);
    n_vec++;
    n_bad++;
    $display("FAIL %s: wait bound expired (t=%0t)", tag, $time);
  endtask

  task automatic model_reset();
    m_mv = 0; m_pos = 0; m_phase = 0; m_el = 0; m_dir = 1'b0;
  endtask

  task automatic model_start(input int d);
    m_mv = d; m_dir = (d > 0); m_el = 0;
  endtask

  task automatic model_edge(input int lv, input bit vld, input bit ae, input bit bo,
                            input bit bc, input bit lo, input bit lc);
    bit tick;
    if (m_mv == 0) begin
      if (bc && !bo) begin
        if (m_pos != POS_MAX && !lc) model_start(1);
      end else if (bo && !bc) begin
        if (m_pos != 0 && !lo) model_start(-1);
      end else if (!bo && !bc && ae && vld) begin
        if (lv >= TH_BRIGHT) begin
          if (m_pos != POS_MAX && !lc) model_start(1);
        end else if (lv <= TH_DARK) begin
          if (m_pos != 0 && !lo) model_start(-1);
        end
      end
    end else begin
      tick = ((m_el % STEP_DIV) == STEP_DIV - 1);
      m_el++;
      if ((m_mv > 0 && lc) || (m_mv < 0 && lo)) begin
        m_pos = (m_mv > 0) ? POS_MAX : 0;
        m_mv  = 0;
      end else begin
        if (tick) begin
          m_pos   = m_pos + m_mv;
          m_phase = (m_phase + m_mv + 4) % 4;
        end
        if (bo || bc || (m_mv > 0 && m_pos == POS_MAX) || (m_mv < 0 && m_pos == 0))
          m_mv = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("coil", 32'(coil), (m_mv == 0) ? 32'd0 : (32'd1 << m_phase));
    check("busy", 32'(busy), 32'(m_mv != 0));
    check("dir",  32'(dir),  32'(m_dir));
    check("pos",  32'(pos),  32'(m_pos));
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge.
  task automatic step(input int lv, input bit vld, input bit bo, input bit bc,
                      input bit lo, input bit lc);
    light_level = 8'(lv);
    light_vld   = vld;
    auto_en     = cur_ae;
    btn_open    = bo;
    btn_close   = bc;
    lim_open    = lo;
    lim_closed  = lc;
    @(posedge clk8m);
    model_edge(lv, vld, cur_ae, bo, bc, lo, lc);
    @(negedge clk8m);
    light_vld = 1'b0; btn_open = 1'b0; btn_close = 1'b0;
    lim_open = 1'b0; lim_closed = 1'b0;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_to_stop(input string tag);
    int g;
    g = 0;
    while (m_mv != 0 && g < 200) begin idle(1); g++; end
    if (m_mv != 0) timeout(tag);
  endtask

  task automatic run_to_pos(input string tag, input int p);
    int g;
    g = 0;
    while (m_pos != p && g < 200) begin idle(1); g++; end
    if (m_pos != p) timeout(tag);
  endtask

  function automatic int pick_level();
    int sel;
    sel = $urandom_range(0, 3);
    case (sel)
      1:       return $urandom_range(76, 84);
      2:       return $urandom_range(176, 184);
      default: return $urandom_range(0, 255);
    endcase
  endfunction

  initial begin
    int g;
    int r;
    model_reset();
    #1;
    check("rst_coil", 32'(coil), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pos",  32'(pos),  32'd0);
    repeat (2) @(negedge clk8m);
    rst = 1'b0;

    // Bright light closes to the end of travel.
    cur_ae = 1'b1;
    step(200, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("s1_busy", 32'(busy), 32'd1);
    check("s1_dir",  32'(dir),  32'd1);
    check("s1_coil", 32'(coil), 32'b0001);
    run_to_stop("s1_stop");
    check("s1_end_pos",  32'(pos),  32'd8);
    check("s1_end_coil", 32'(coil), 32'd0);

    // Dark light opens back to zero.
    step(50, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("s2_dir", 32'(dir), 32'd0);
    run_to_stop("s2_stop");
    check("s2_end_pos", 32'(pos), 32'd0);

    // Hysteresis band at both ends; threshold edges.
    step(120, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);
    step(81, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(180, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_to_stop("s3_close");
    step(120, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(179, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("s3_busy", 32'(busy), 32'd0);
    step(80, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    run_to_stop("s3_open");

    // Manual close, stop at 3, manual open to zero.
    cur_ae = 1'b0;
    step(200, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    run_to_pos("s4_pos3", 3);
    step(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("s4_stop_pos",  32'(pos),  32'd3);
    check("s4_stop_coil", 32'(coil), 32'd0);
    idle(6);
    step(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_to_stop("s4_open");
    check("s4_open_pos", 32'(pos), 32'd0);

    // Closed limit on a tick cycle at pos 5.
    step(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    g = 0;
    while (!(m_pos == 5 && (m_el % STEP_DIV) == STEP_DIV - 1) && g < 200) begin idle(1); g++; end
    if (g >= 200) timeout("s5_wait");
    step(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("s5_lim_pos",  32'(pos),  32'd8);
    check("s5_lim_busy", 32'(busy), 32'd0);
    step(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_to_stop("s5_open");
    step(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("s5_limopen_ign", 32'(busy), 32'd1);
    run_to_stop("s5_close");

    // Both buttons ignored; async reset mid-close.
    step(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_to_stop("s6_open");
    step(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("s6_both_busy", 32'(busy), 32'd0);
    step(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_to_pos("s6_pos4", 4);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check("s6_rst_coil", 32'(coil), 32'd0);
    check("s6_rst_pos",  32'(pos),  32'd0);
    check("s6_rst_busy", 32'(busy), 32'd0);
    @(negedge clk8m);
    rst = 1'b0;

    // Random traffic.
    cur_ae = 1'b1;
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 999);
      if (r < 3) cur_ae = ~cur_ae;
      if (r < 40)       step(pick_level(), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      else if (r < 46)  step(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      else if (r < 52)  step(0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      else if (r < 56)  step(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      else if (r < 60)  step(0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      else if (r < 62)  step(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      else if (r < 64)  step(pick_level(), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      else              idle(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
